regfile: RTL

- General-purpose register file for the MIPS pipeline.
- It is the receiving end of the write-back triple (wd, wreg, wdata) that the execute stage produces and the pipeline carries to write-back.
- It serves the decode stage through two independent read ports.
- It holds 32 x 32-bit registers, with $0 hardwired to zero and same-cycle write-to-read bypass.

---
 rtl/regfile.sv | 60 ++++++
 1 files changed

// File: rtl/regfile.sv
// 32 x 32-bit MIPS general-purpose register file: one write port fed by write-back,
// two combinational read ports for decode, $0 hardwired to zero, write-to-read bypass.
module regfile #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned NREG   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2
);

   logic [DATA_W-1:0] regs [NREG];
   logic              wr_en;

   // Index 0 is never written, so regs[0] holds the value cleared at reset forever.
   assign wr_en = we && (waddr != '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[waddr] <= wdata;
      end
   end

   // Bypass the in-flight write so decode never sees a stale value.
   always_comb begin
      rdata1 = '0;
      if (rst && re1 && (raddr1 != '0)) begin
         if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
         end else begin
            rdata1 = regs[raddr1];
         end
      end
   end

   always_comb begin
      rdata2 = '0;
      if (rst && re2 && (raddr2 != '0)) begin
         if (we && (waddr == raddr2)) begin
            rdata2 = wdata;
         end else begin
            rdata2 = regs[raddr2];
         end
      end
   end

endmodule
